// File: rtl/skin_binary_pipe_if.sv
// Video-in / binarised-video-out bundle for skin_binary_pipe.
// The master drives pixels and controls; the slave (the pipe) returns delayed video and frame counts.
interface skin_binary_pipe_if #(
  parameter int CB_W  = 8,
  parameter int CNT_W = 22
);
  logic                in_de;
  logic                in_hsync;
  logic                in_vsync;
  logic [2*CB_W-1:0]   in_cbcr;
  logic [7:0]          threshold;
  logic [1:0]          mode;
  logic                out_de;
  logic                out_hsync;
  logic                out_vsync;
  logic [7:0]          out_data;
  logic [CNT_W-1:0]    fg_count;
  logic                fg_count_valid;

  modport master (
    output in_de, in_hsync, in_vsync, in_cbcr, threshold, mode,
    input  out_de, out_hsync, out_vsync, out_data, fg_count, fg_count_valid
  );

  modport slave (
    input  in_de, in_hsync, in_vsync, in_cbcr, threshold, mode,
    output out_de, out_hsync, out_vsync, out_data, fg_count, fg_count_valid
  );
endinterface

// File: rtl/skin_binary_pipe.sv
// Skin-colour detector: CbCr ellipse distance -> gray likelihood -> per-frame thresholded mask,
// eight-stage pipeline with a per-frame foreground pixel counter.
module skin_binary_pipe #(
  parameter int         CB_W    = 8,
  parameter int         X_MAX   = 320,
  parameter int         CNT_W   = 22,
  parameter logic [7:0] THR_RST = 8'd128
) (
  input logic            clk,
  input logic            rst,
  skin_binary_pipe_if.slave bus
);

  // Sideband shift registers cover stages 1..7; stage 8 is the output register.
  localparam int STAGES = 7;
  localparam logic signed [19:0] XMAX_S = 20'(X_MAX);
  localparam logic [8:0]         XMAX_9 = 9'(X_MAX);

  logic [7:0] cb_in, cr_in;
  logic       unused_bits;
  assign cb_in       = bus.in_cbcr[2*CB_W-1 -: 8];
  assign cr_in       = bus.in_cbcr[CB_W-1 -: 8];
  assign unused_bits = ^bus.in_cbcr;

  logic [7:0]        thr_sh;
  logic [1:0]        mode_sh;
  logic [STAGES-1:0] de_sr, hs_sr, vs_sr;
  logic [7:0]        thr_p  [STAGES];
  logic [1:0]        mode_p [STAGES];

  logic [7:0]  c1, r1, c2, r2;
  logic [15:0] cb2_2, cr2_2, cbcr_2;
  logic [14:0] t_cb2_3, t_cb_3;
  logic [13:0] t_cr2_3, t_cr_3;
  logic [12:0] t_x_3;
  logic [8:0]  x4, x5, p2_5, x6, p3_6, x7;
  logic [11:0] g86_6;
  logic [10:0] g175_6;
  logic [7:0]  gray7;

  logic             out_de_q, out_hs_q, out_vs_q, fg_valid_q;
  logic [7:0]       out_data_q;
  logic [CNT_W-1:0] acc, fg_count_q;

  logic signed [19:0] x_sum;
  logic [8:0]         x_clamp;
  logic [11:0]        t_p3;
  logic signed [15:0] g_sum;
  logic [7:0]         g_clamp;
  logic               in_rise, out_rise, fg7, acc_inc;
  logic [7:0]         data_next;
  logic [CNT_W-1:0]   acc_next;

  always_comb begin
    x_sum = 20'sd7880 + signed'(20'(t_cb2_3)) + signed'(20'(t_cr2_3))
          - signed'(20'(t_x_3)) - signed'(20'(t_cb_3)) - signed'(20'(t_cr_3));
    if (x_sum < 20'sd0)
      x_clamp = '0;
    else if (x_sum > XMAX_S)
      x_clamp = XMAX_9;
    else
      x_clamp = x_sum[8:0];

    t_p3  = 12'((12'(p3_6) * 12'd7) >> 1);
    g_sum = 16'sd238 - signed'(16'(t_p3)) + signed'(16'(g86_6)) - signed'(16'(g175_6));
    if (g_sum < 16'sd0)
      g_clamp = '0;
    else if (g_sum > 16'sd255)
      g_clamp = 8'hFF;
    else
      g_clamp = g_sum[7:0];
  end

  // Output select and frame bookkeeping act on stage-7 values as they enter the output register.
  always_comb begin
    in_rise  = bus.in_vsync & ~vs_sr[0];
    out_rise = vs_sr[STAGES-1] & ~out_vs_q;
    fg7      = (gray7 <= thr_p[STAGES-1]);
    case (mode_p[STAGES-1])
      2'd0:    data_next = fg7 ? 8'hFF : 8'h00;
      2'd1:    data_next = gray7;
      2'd2:    data_next = x7[8:1];
      default: data_next = fg7 ? gray7 : 8'h00;
    endcase
    if (!de_sr[STAGES-1])
      data_next = 8'h00;
    acc_inc  = de_sr[STAGES-1] & fg7;
    acc_next = (acc_inc && (acc != '1)) ? acc + CNT_W'(1) : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thr_sh     <= THR_RST;
      mode_sh    <= 2'd0;
      de_sr      <= '0;
      hs_sr      <= '0;
      vs_sr      <= '0;
      for (int i = 0; i < STAGES; i++) begin
        thr_p[i]  <= '0;
        mode_p[i] <= '0;
      end
      c1         <= '0;
      r1         <= '0;
      c2         <= '0;
      r2         <= '0;
      cb2_2      <= '0;
      cr2_2      <= '0;
      cbcr_2     <= '0;
      t_cb2_3    <= '0;
      t_cr2_3    <= '0;
      t_x_3      <= '0;
      t_cb_3     <= '0;
      t_cr_3     <= '0;
      x4         <= '0;
      x5         <= '0;
      p2_5       <= '0;
      x6         <= '0;
      p3_6       <= '0;
      g86_6      <= '0;
      g175_6     <= '0;
      x7         <= '0;
      gray7      <= '0;
      out_de_q   <= 1'b0;
      out_hs_q   <= 1'b0;
      out_vs_q   <= 1'b0;
      out_data_q <= '0;
      acc        <= '0;
      fg_count_q <= '0;
      fg_valid_q <= 1'b0;
    end else begin
      if (in_rise) begin
        thr_sh  <= bus.threshold;
        mode_sh <= bus.mode;
      end
      de_sr     <= {de_sr[STAGES-2:0], bus.in_de};
      hs_sr     <= {hs_sr[STAGES-2:0], bus.in_hsync};
      vs_sr     <= {vs_sr[STAGES-2:0], bus.in_vsync};
      thr_p[0]  <= thr_sh;
      mode_p[0] <= mode_sh;
      for (int i = 1; i < STAGES; i++) begin
        thr_p[i]  <= thr_p[i-1];
        mode_p[i] <= mode_p[i-1];
      end

      c1      <= cb_in;
      r1      <= cr_in;
      cb2_2   <= 16'(c1) * 16'(c1);
      cr2_2   <= 16'(r1) * 16'(r1);
      cbcr_2  <= 16'(c1) * 16'(r1);
      c2      <= c1;
      r2      <= r1;
      t_cb2_3 <= 15'((21'(cb2_2) * 21'd22) >> 6);
      t_cr2_3 <= 14'((20'(cr2_2) * 20'd15) >> 6);
      t_x_3   <= 13'(cbcr_2 >> 3);
      t_cb_3  <= 15'(c2) * 15'd68;
      t_cr_3  <= 14'(r2) * 14'd51;
      x4      <= x_clamp;
      p2_5    <= 9'((18'(x4) * 18'(x4)) >> 9);
      x5      <= x4;
      p3_6    <= 9'((18'(x5) * 18'(p2_5)) >> 9);
      g86_6   <= 12'((16'(p2_5) * 16'd86) >> 4);
      g175_6  <= 11'((17'(x5) * 17'd175) >> 6);
      x6      <= x5;
      gray7   <= g_clamp;
      x7      <= x6;

      out_de_q   <= de_sr[STAGES-1];
      out_hs_q   <= hs_sr[STAGES-1];
      out_vs_q   <= vs_sr[STAGES-1];
      out_data_q <= data_next;
      fg_valid_q <= out_rise;
      if (out_rise) begin
        fg_count_q <= acc_next;
        acc        <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end

  assign bus.out_de         = out_de_q;
  assign bus.out_hsync      = out_hs_q;
  assign bus.out_vsync      = out_vs_q;
  assign bus.out_data       = out_data_q;
  assign bus.fg_count       = fg_count_q;
  assign bus.fg_count_valid = fg_valid_q;

endmodule

// File: doc/skin_binary_pipe.md
SKIN_BINARY_PIPE -- requirements
Module: skin_binary_pipe

Interface
REQ-001 Parameter CB_W, default 8: width of each chroma component; only the upper 8 bits of each component enter the arithmetic.
REQ-002 Parameter X_MAX, default 320: upper clamp of ellipse distance x (9-bit, must be ≤ 511).
REQ-003 Parameter CNT_W, default 22: width of the per-frame foreground counter.
REQ-004 Parameter THR_RST, default 8'd128: reset value of the shadow threshold.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_de / in_hsync / in_vsync  in  1 each  video timing, qualified per pixel.
REQ-008 in_cbcr  in  2*CB_W  Cb in upper half, Cr in lower half.
REQ-009 threshold  in  8  binarisation threshold, shadowed per frame.
REQ-010 mode  in  2  output select, shadowed per frame.
REQ-011 out_de / out_hsync / out_vsync  out  1 each  timing delayed to match out_data.
REQ-012 out_data  out  8  binary, gray or x-derived pixel.
REQ-013 fg_count  out  CNT_W  foreground pixel count of the last completed frame.
REQ-014 fg_count_valid  out  1  one-cycle strobe when fg_count updates.

Function
REQ-015 Stage-1 arithmetic SHALL use signed intermediates: x = 7880 + (22*cb²>>6) + (15*cr²>>6) − (8*cb*cr>>6) − 68*cb − 51*cr, where each >>6 truncates its own non-negative product.
REQ-016 x SHALL be clamped to the range 0..X_MAX; negative results become 0.
REQ-017 Stage-2 arithmetic: p2 = (x*x)>>9, p3 = (x*p2)>>9, gray = 238 − ((7*p3)>>1) + ((86*p2)>>4) − ((175*x)>>6), signed, clamped to 0..255.
REQ-018 Foreground is defined as gray ≤ shadow threshold; binary = 8'hFF for foreground, 8'h00 otherwise.
REQ-019 mode 0 SHALL output binary, mode 1 gray, mode 2 x[8:1], and mode 3 gray with binary=0 pixels forced to 8'h00.
REQ-020 Latency from in_* to out_* SHALL be exactly 8 cycles, fully pipelined with one pixel per cycle and no stalls, independent of parameters.
REQ-021 out_de/hsync/vsync SHALL be the inputs delayed by 8 registers.
REQ-022 out_data SHALL be 8'h00 whenever out_de = 0.
REQ-023 Shadow threshold and mode SHALL load from their inputs on the rising edge of in_vsync (0→1) only; mid-frame input changes have no effect until the next edge.
REQ-024 A pixel's threshold and mode are those in effect when it entered, so the shadow values SHALL travel with the pipeline.
REQ-025 The accumulator SHALL increment on cycles with out_de = 1 and binary foreground, saturating at 2^CNT_W − 1.
REQ-026 On the rising edge of out_vsync, fg_count SHALL receive the accumulator value including the same-cycle increment, the accumulator SHALL clear, and fg_count_valid SHALL pulse for 1 cycle.
REQ-027 Simultaneous rising edges of in_vsync and out_vsync SHALL be handled independently with no interaction.

Reset
REQ-028 While rst = 1, all pipeline registers, out_*, fg_count, fg_count_valid and the accumulator SHALL be 0.
REQ-029 While rst = 1, the shadow threshold SHALL be THR_RST and the shadow mode SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard all in-flight pixels, with outputs 0 the cycle after rst is sampled high.
REQ-031 After reset, the first out_vsync rising edge SHALL latch the partial count normally.
REQ-032 The first valid output after rst deasserts SHALL appear 8 cycles after the first post-reset input.

Verification
REQ-033 Cb=0, Cr=0, de=1, mode 1 → x clamps to 320; out_data = 8'd1 at cycle 8.
REQ-034 Cb=128, Cr=128, threshold 100, mode 0 → x=72, gray=92; out_data = 8'hFF. With threshold 80 (new frame) → 8'h00.
REQ-035 Threshold changed mid-frame from 100 to 80 with Cb=Cr=128 → out_data stays 8'hFF until pixels after the next in_vsync rise.
REQ-036 Frame of 1000 de pixels with 300 foreground, then vsync rise → fg_count = 300 and fg_count_valid high for 1 cycle, 8 cycles after in_vsync rise.
REQ-037 rst pulsed mid-line → outputs 0 the next cycle; pipeline refills; the next frame count excludes pre-reset pixels.
REQ-038 CB_W=10 with Cb=Cr=10'd512 → results identical to the 8-bit 128/128 case (x=72, gray=92).
